intersection_sequencer: RTL
===========================

// Module: intersection_sequencer
// PURPOSE
//  Master timing and phase sequencer for the highway/country-road intersection.
//  Owns the seconds prescaler, phase timer and car-request latch.
//  Drives time_out/cr_ena into the country-road light controller (idle->green->yellow->idle).
//  Drives the highway LEDs directly, so both roads always change on the same clk edge.
// PARAMETERS
//  CLK_DIV   50_000_000  clk cycles per timer tick (1 s)
//  HW_MIN_G  10          minimum highway green, ticks
//  YEL       3           yellow duration (both roads), ticks
//  CR_MIN_G  5           minimum country-road green, ticks
//  CR_MAX_G  15          maximum country-road green incl. extensions, ticks
//  CR_EXT    2           green extension per re-detected car, ticks
//  Legal values: all >=1 and CR_MIN_G<=CR_MAX_G; elaboration error otherwise.
// PORTS
//  clk       in   1  system clock
//  rst_n     in   1  asynchronous, active-low reset
//  cr_car    in   1  country-road car sensor, level, asynchronous
//  force_hw  in   1  emergency: force highway green, level, asynchronous
//  cr_ena    out  1  enable to CR controller; qualifies time_out in its idle state
//  time_out  out  1  one-cycle phase-end pulse to CR controller
//  hw_led    out  3  highway lamps: 100 green, 010 yellow, 001 red
//  phase     out  2  00 HWG, 01 HWY, 10 CRG, 11 CRY
//  cr_req    out  1  latched pending country-road request
// BEHAVIOUR
//  Reset: phase=HWG, timer=HW_MIN_G, prescaler=0, ext count=0, cr_req=0, time_out=0, cr_ena=0, hw_led=100, synchronisers cleared.
//  Reset mid-operation returns everything to these values immediately (async).
//  cr_car and force_hw each pass a 2-FF synchroniser (2-cycle latency); below they mean the synchronised values.
//  Prescaler: reset to 0 on phase entry; tick every CLK_DIV cycles.
//  Timer: loaded on phase entry, decremented on tick, saturates at 0.
//  Exit sequence: exit condition true at edge E -> time_out=1 for cycle E..E+1, phase unchanged.
//   At E+1: phase advances, timer reloads, time_out=0.
//   Unconditioned phase length = N*CLK_DIV+1 cycles.
//  HWG (hw_led 100): exit when timer==0 && cr_req; waits indefinitely otherwise. force_hw ignored. -> HWY, load YEL.
//  HWY (hw_led 010): cr_ena=1 throughout. Exit when timer==0.
//   If force_hw is high at exit, cr_ena=0 in the time_out cycle, next phase=HWG (load HW_MIN_G), cr_req kept.
//   Otherwise next phase=CRG (load CR_MIN_G, ext count=CR_MIN_G, cr_req cleared).
//  CRG (hw_led 001): cars extend green, they do not set cr_req.
//   At timer==0 with cr_car high and ext count<CR_MAX_G: reload min(CR_EXT, CR_MAX_G-ext count) and add it to ext count; no time_out.
//   Exit when timer==0 && (!cr_car || ext count>=CR_MAX_G), or on force_hw at any time. -> CRY, load YEL.
//  CRY (hw_led 001): exit when timer==0. -> HWG, load HW_MIN_G. force_hw ignored.
//  cr_req: set by cr_car high in HWG, HWY or CRY; cleared only on CRG entry.
//   Set-and-clear in the same cycle: the clear wins.
//  cr_ena=0 outside HWY. time_out never high on two consecutive cycles.
// TESTING (CLK_DIV=4 HW_MIN_G=4 YEL=2 CR_MIN_G=3 CR_MAX_G=6 CR_EXT=2)
//  No car, 200 cycles after reset -> phase=00, hw_led=100, time_out never 1, cr_ena=0.
//  cr_car pulse 3 cycles at cycle 5 -> cr_req=1 at cycle 7.
//   Then HWG->HWY->CRG->CRY->HWG; time_out 4 pulses; HWY and CRY 9 cycles each, CRG 13.
//   cr_ena=1 only in HWY; CR controller LEDs go red->green->yellow->red.
//  cr_car held high -> CRG lasts 6 ticks (3+2+1, capped at CR_MAX_G).
//   cr_req set in CRY; the next HWG lasts exactly 17 cycles before HWY.
//  force_hw raised at CRG tick 1 -> time_out within 3 cycles, then CRY 9 cycles, then HWG.
//  force_hw held across HWY expiry -> cr_ena=0 in the time_out cycle, phase back to 00.
//   CR controller stays red; cr_req still 1; HWY re-entered after HW_MIN_G.
//  rst_n low mid-CRG -> all outputs at reset values before the next clk edge.
//   Release -> normal HWG timing resumes.

Source files
------------

// File: rtl/intersection_sequencer.sv
// Phase/timer sequencer for the highway/country-road intersection; drives highway lamps and the CR controller handshake.
// Latency: inputs pass a 2-FF synchroniser; a phase ends one cycle after its exit condition (time_out cycle).
// Backpressure: none; HWG holds indefinitely until a country-road request is latched.
module intersection_sequencer #(
    parameter int CLK_DIV  = 50_000_000,
    parameter int HW_MIN_G = 10,
    parameter int YEL      = 3,
    parameter int CR_MIN_G = 5,
    parameter int CR_MAX_G = 15,
    parameter int CR_EXT   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cr_car,
    input  logic       force_hw,
    output logic       cr_ena,
    output logic       time_out,
    output logic [2:0] hw_led,
    output logic [1:0] phase,
    output logic       cr_req
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int TMAX = max2(max2(HW_MIN_G, YEL), max2(CR_MAX_G, CR_EXT));
    localparam int TW   = $clog2(TMAX + 1);
    localparam int PW   = $clog2(CLK_DIV + 1);

    localparam logic [TW-1:0] HWG_L  = TW'(HW_MIN_G);
    localparam logic [TW-1:0] YEL_L  = TW'(YEL);
    localparam logic [TW-1:0] MING_L = TW'(CR_MIN_G);
    localparam logic [TW-1:0] MAXG_L = TW'(CR_MAX_G);
    localparam logic [TW-1:0] EXT_L  = TW'(CR_EXT);
    localparam logic [PW-1:0] PDIV_L = PW'(CLK_DIV - 1);

    if (CLK_DIV < 1 || HW_MIN_G < 1 || YEL < 1 || CR_MIN_G < 1 || CR_MAX_G < 1 ||
        CR_EXT < 1 || CR_MIN_G > CR_MAX_G) begin : g_bad_params
        $error("intersection_sequencer: illegal parameter set");
    end

    typedef enum logic [1:0] {
        HWG = 2'b00,
        HWY = 2'b01,
        CRG = 2'b10,
        CRY = 2'b11
    } phase_t;

    phase_t         state, state_n;
    logic [PW-1:0]  presc, presc_n;
    logic [TW-1:0]  timer, timer_n, tmr_dec, ext_cnt, ext_n, ext_rem, ext_amt;
    logic           car_s1, car_s2, frc_s1, frc_s2;
    logic           to_n, to_hw, to_hw_n, req_n, req_set, req_clr;
    logic           tick, zero;

    // Synchronisers and all sequencer state; reset returns to HWG entry values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            car_s1   <= 1'b0;
            car_s2   <= 1'b0;
            frc_s1   <= 1'b0;
            frc_s2   <= 1'b0;
            state    <= HWG;
            presc    <= '0;
            timer    <= HWG_L;
            ext_cnt  <= '0;
            cr_req   <= 1'b0;
            time_out <= 1'b0;
            to_hw    <= 1'b0;
        end else begin
            car_s1   <= cr_car;
            car_s2   <= car_s1;
            frc_s1   <= force_hw;
            frc_s2   <= frc_s1;
            state    <= state_n;
            presc    <= presc_n;
            timer    <= timer_n;
            ext_cnt  <= ext_n;
            cr_req   <= req_n;
            time_out <= to_n;
            to_hw    <= to_hw_n;
        end
    end

    // Next-state: exit is judged on the timer value this edge would produce, so
    // time_out rises on the same edge the timer reaches zero
    always_comb begin
        tick     = (presc == PDIV_L);
        tmr_dec  = (tick && timer != '0) ? timer - TW'(1) : timer;
        zero     = (tmr_dec == '0);
        ext_rem  = MAXG_L - ext_cnt;
        ext_amt  = (EXT_L < ext_rem) ? EXT_L : ext_rem;
        state_n  = state;
        presc_n  = tick ? '0 : presc + PW'(1);
        timer_n  = tmr_dec;
        ext_n    = ext_cnt;
        to_n     = 1'b0;
        to_hw_n  = to_hw;
        req_set  = car_s2 && (state != CRG);
        req_clr  = 1'b0;
        if (time_out) begin
            presc_n = '0;
            to_hw_n = 1'b0;
            case (state)
                HWG: begin
                    state_n = HWY;
                    timer_n = YEL_L;
                end
                HWY: begin
                    if (to_hw) begin
                        state_n = HWG;
                        timer_n = HWG_L;
                    end else begin
                        state_n = CRG;
                        timer_n = MING_L;
                        ext_n   = MING_L;
                        req_clr = 1'b1;
                    end
                end
                CRG: begin
                    state_n = CRY;
                    timer_n = YEL_L;
                end
                default: begin
                    state_n = HWG;
                    timer_n = HWG_L;
                end
            endcase
        end else begin
            case (state)
                HWG: to_n = zero && cr_req;
                HWY: begin
                    if (zero) begin
                        to_n    = 1'b1;
                        to_hw_n = frc_s2;
                    end
                end
                CRG: begin
                    if (frc_s2) begin
                        to_n = 1'b1;
                    end else if (zero) begin
                        if (car_s2 && ext_cnt < MAXG_L) begin
                            timer_n = ext_amt;
                            ext_n   = ext_cnt + ext_amt;
                        end else begin
                            to_n = 1'b1;
                        end
                    end
                end
                default: to_n = zero;
            endcase
        end
        req_n = req_clr ? 1'b0 : (req_set ? 1'b1 : cr_req);
    end

    // Lamp and handshake decode from registered state
    always_comb begin
        phase  = state;
        cr_ena = (state == HWY) && !(time_out && to_hw);
        case (state)
            HWG:     hw_led = 3'b100;
            HWY:     hw_led = 3'b010;
            default: hw_led = 3'b001;
        endcase
    end

endmodule
